i2c_master: RTL
===============

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 60, giving system clocks per quarter SCL period; the legal minimum is 2.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd  in  3  command code: 0 START, 1 WRITE, 2 READ, 3 STOP, 4-7 NOP.
- wdata  in  8  byte for WRITE, sampled at accept.
- rd_nack  in  1  acknowledge bit sent after a READ (1 = NACK), sampled at accept.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rdata  out  8  byte received by the last READ.
- ack_in  out  1  ACK bit sampled by the last WRITE (0 = ACK).
- busy  out  1  inverse of cmd_ready.
- scl_o  out  1  SCL drive; 0 pulls low, 1 releases.
- sda_o  out  1  SDA drive; 0 pulls low, 1 releases.
- sda_i  in  1  SDA line as seen on the bus.

Function
REQ-003 A command SHALL be accepted only in a cycle where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL drop in the following cycle.
REQ-004 The tick counter SHALL clear on accept and count 0..CLK_DIV-1 while busy; a tick occurs when the count reaches CLK_DIV-1.
REQ-005 Each step SHALL be four phases, 0-3, with the phase advancing on each tick.
REQ-006 START phases SHALL be: ph0 sda_o=1 with SCL unchanged; ph1 scl_o=1; ph2 sda_o=0; ph3 scl_o=0. This gives a repeated START when SCL is already low.
REQ-007 A byte SHALL be 9 bit-steps, MSB first. Each bit-step is: ph0 set sda_o with scl_o=0; ph1 scl_o=1; ph2 sample sda_i; ph3 scl_o=0.
REQ-008 WRITE SHALL drive the wdata bits on bit-steps 1-8, set sda_o=1 on bit-step 9, and latch the bit-step 9 sample into ack_in.
REQ-009 READ SHALL set sda_o=1 on bit-steps 1-8, shift the samples into rdata MSB first, and drive rd_nack on bit-step 9.
REQ-010 rdata SHALL update only at READ completion; ack_in SHALL update only at WRITE completion.
REQ-011 STOP phases SHALL be: ph0 sda_o=0; ph1 scl_o=1; ph2 sda_o=1; ph3 hold. STOP ends with scl_o=1 and sda_o=1.
REQ-012 Completion SHALL occur on the final ph3 tick. In the cycle after that tick, rsp_valid=1 for exactly one cycle and cmd_ready=1.
REQ-013 Latency from accept to rsp_valid SHALL be 4*CLK_DIV cycles for START and STOP, and 36*CLK_DIV cycles for WRITE and READ.
REQ-014 A new command MAY be accepted in the same cycle rsp_valid=1, giving back-to-back commands with no idle bus time.
REQ-015 The NOP codes (4-7) SHALL raise rsp_valid the cycle after accept and SHALL NOT change the bus pins.
REQ-016 While idle, scl_o and sda_o SHALL hold their last values.
REQ-017 WRITE or READ without a preceding START SHALL still execute as specified.
REQ-018 The block SHALL NOT perform arbitration, clock-stretch detection, or any check of sda_i against sda_o.
REQ-019 cmd_valid held high while busy SHALL have no effect.
REQ-020 CLK_DIV=1 SHALL be unsupported; the block's behaviour is then undefined.

Reset
REQ-021 With rst=1, asynchronously: scl_o=1, sda_o=1, cmd_ready=1, busy=0, rsp_valid=0, rdata=0x00, ack_in=0, and tick, phase and bit counters all 0.
REQ-022 Reset mid-command SHALL abort with no rsp_valid and release both lines immediately.
REQ-023 The first command after rst is deasserted SHALL be acceptable on the first clock edge.

Verification (CLK_DIV=4, open-drain bus model with a PCF8583-like slave at 0xA0)
REQ-024 Reset then release -> scl_o=1, sda_o=1, cmd_ready=1, rsp_valid=0, rdata=0x00.
REQ-025 START then STOP, back to back -> SDA falls while SCL high 8 cycles after the first accept; rsp_valid at +16 and +32 cycles; bus ends with SCL=1, SDA=1.
REQ-026 START, WRITE 0xA0 with slave ACK -> bits 1,0,1,0,0,0,0,0 stable during SCL high; SDA released on bit 9; ack_in=0; rsp_valid 144 cycles after the WRITE accept.
REQ-027 READ with slave driving 0x5A and rd_nack=1 -> rdata=0x5A at rsp_valid; sda_o=1 throughout bit 9.
REQ-028 WRITE 0x42 with no slave (sda_i=1) -> ack_in=1; a following STOP completes normally.
REQ-029 rst asserted during bit-step 4 of a WRITE -> scl_o=1 and sda_o=1 within the same cycle, no rsp_valid; next START accepted and completes in 16 cycles.

Source files
------------

// File: rtl/i2c_master.sv
// Byte-level I2C bus master: executes START / WRITE / READ / STOP commands one at a time,
// driving open-drain SCL/SDA with four quarter-period phases per bit-step.
module i2c_master #(
    parameter int CLK_DIV = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [7:0] wdata,
    input  logic       rd_nack,
    output logic       rsp_valid,
    output logic [7:0] rdata,
    output logic       ack_in,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] TICK_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WRITE,
        S_READ,
        S_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [1:0]    phase;
    logic [3:0]    bit_cnt;
    logic [7:0]    tx_bits;
    logic [7:0]    rx_bits;
    logic          ack_bit;
    logic          tick;

    assign busy      = (state != S_IDLE);
    assign cmd_ready = ~busy;
    assign tick      = busy && (tick_cnt == TICK_MAX);

    // The accept cycle itself is tick slot 0, so the counter starts at 1 after the accept edge;
    // every pin action belongs to the edge that enters its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            phase     <= 2'd0;
            bit_cnt   <= 4'd0;
            tx_bits   <= 8'h00;
            rx_bits   <= 8'h00;
            ack_bit   <= 1'b0;
            rsp_valid <= 1'b0;
            rdata     <= 8'h00;
            ack_in    <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            if (!busy) begin
                if (cmd_valid) begin
                    tick_cnt <= TICK_ONE;
                    phase    <= 2'd0;
                    bit_cnt  <= 4'd0;
                    case (cmd)
                        3'd0: begin
                            state <= S_START;
                            sda_o <= 1'b1;
                        end
                        3'd1: begin
                            state   <= S_WRITE;
                            scl_o   <= 1'b0;
                            sda_o   <= wdata[7];
                            tx_bits <= {wdata[6:0], 1'b1};
                        end
                        3'd2: begin
                            state   <= S_READ;
                            scl_o   <= 1'b0;
                            sda_o   <= 1'b1;
                            tx_bits <= {7'h7F, rd_nack};
                        end
                        3'd3: begin
                            state <= S_STOP;
                            sda_o <= 1'b0;
                        end
                        default: rsp_valid <= 1'b1;
                    endcase
                end
            end else if (!tick) begin
                tick_cnt <= tick_cnt + TICK_ONE;
            end else begin
                tick_cnt <= '0;
                phase    <= phase + 2'd1;
                case (state)
                    S_START: begin
                        case (phase)
                            2'd0: scl_o <= 1'b1;
                            2'd1: sda_o <= 1'b0;
                            2'd2: scl_o <= 1'b0;
                            default: begin
                                state     <= S_IDLE;
                                rsp_valid <= 1'b1;
                            end
                        endcase
                    end
                    S_STOP: begin
                        case (phase)
                            2'd0: scl_o <= 1'b1;
                            2'd1: sda_o <= 1'b1;
                            2'd3: begin
                                state     <= S_IDLE;
                                rsp_valid <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                    S_WRITE, S_READ: begin
                        case (phase)
                            2'd0: scl_o <= 1'b1;
                            2'd1: begin
                                if (bit_cnt == 4'd8) begin
                                    ack_bit <= sda_i;
                                end else begin
                                    rx_bits <= {rx_bits[6:0], sda_i};
                                end
                            end
                            2'd2: scl_o <= 1'b0;
                            default: begin
                                if (bit_cnt == 4'd8) begin
                                    state     <= S_IDLE;
                                    rsp_valid <= 1'b1;
                                    if (state == S_WRITE) begin
                                        ack_in <= ack_bit;
                                    end else begin
                                        rdata <= rx_bits;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    scl_o   <= 1'b0;
                                    sda_o   <= tx_bits[7];
                                    tx_bits <= {tx_bits[6:0], 1'b1};
                                end
                            end
                        endcase
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
